// File: rtl/encrypt_seq.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_seq
// Purpose  : Front-end sequencer for the encrypt stage. Loads a 4-word block
//            into data memory, runs start/stop with encrypt, streams results.
// Options  : define ENCRYPT_SEQ_TIMEOUT_EN for the START/RUN watchdog and err.
// Revision : 1.0 - initial release
// ============================================================================
module encrypt_seq #(
  parameter int         TIMEOUT = 1023,
  parameter logic [8:0] RD_BASE = 9'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        mem_sel,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  enc_start,
  input  logic [2:0]  enc_stop,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] c_LOAD    = 3'd0;
  localparam logic [2:0] c_START   = 3'd1;
  localparam logic [2:0] c_RUN     = 3'd2;
  localparam logic [2:0] c_FETCH   = 3'd3;
  localparam logic [2:0] c_WAIT_RD = 3'd4;
  localparam logic [2:0] c_DRAIN   = 3'd5;

  localparam logic [2:0] c_STOP_ACK  = 3'b001;
  localparam logic [2:0] c_STOP_DONE = 3'b010;
  localparam logic [1:0] c_START_GO  = 2'b01;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  enc_start_q, enc_start_d;
  logic        mem_sel_q, mem_sel_d;

  logic accept;
  logic in_enc;
  logic ack;
  logic done;
  logic wd_expire;

  assign s_ready = (state_q == c_LOAD);
  assign accept  = s_valid & s_ready;
  assign busy    = !((state_q == c_LOAD) && (cnt_q == 2'd0));
  assign in_enc  = (state_q == c_START) || (state_q == c_RUN);
  // An ack only counts once start is actually being driven to encrypt.
  assign ack     = (state_q == c_START) && (enc_start_q == c_START_GO) &&
                   (enc_stop == c_STOP_ACK);
  assign done    = (state_q == c_RUN) && (enc_stop == c_STOP_DONE);

`ifdef ENCRYPT_SEQ_TIMEOUT_EN
  localparam logic [9:0] c_TIMEOUT = 10'(TIMEOUT);

  logic [9:0] wd_q, wd_d;
  logic       err_q, err_d;

  assign wd_d      = in_enc ? wd_q + 10'd1 : 10'd0;
  assign wd_expire = in_enc && (wd_d == c_TIMEOUT);

  always_comb begin
    err_d = err_q;
    if (accept)    err_d = 1'b0;
    if (wd_expire) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= 10'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= c_LOAD;
      cnt_q       <= 2'd0;
      m_data_q    <= 32'd0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      mem_addr_q  <= 9'd0;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      enc_start_q <= 2'b00;
      mem_sel_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      enc_start_q <= enc_start_d;
      mem_sel_q   <= mem_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = c_START;
        end
      end
      c_START:   if (ack)  state_d = c_RUN;
      c_RUN:     if (done) state_d = c_FETCH;
      c_FETCH:   state_d = c_WAIT_RD;
      c_WAIT_RD: state_d = c_DRAIN;
      c_DRAIN: begin
        if (m_ready && m_valid_q) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3) ? c_LOAD : c_FETCH;
        end
      end
      default: begin
        state_d = c_LOAD;
        cnt_d   = 2'd0;
      end
    endcase
    if (wd_expire) begin
      state_d = c_LOAD;
      cnt_d   = 2'd0;
    end
  end

  always_comb begin
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    enc_start_d = enc_start_q;
    mem_sel_d   = mem_sel_q;
    case (state_q)
      c_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {7'b0, cnt_q};
          mem_wdata_d = s_data;
        end
      end
      c_START: begin
        // First START cycle keeps the port so the 4th write lands; start follows.
        mem_sel_d = 1'b0;
        if (ack)             enc_start_d = 2'b00;
        else if (!mem_sel_q) enc_start_d = c_START_GO;
      end
      c_RUN:     if (done) mem_sel_d = 1'b1;
      c_FETCH:   mem_addr_d = RD_BASE + {7'b0, cnt_q};
      c_WAIT_RD: begin
        m_data_d  = mem_rdata;
        m_valid_d = 1'b1;
        m_last_d  = (cnt_q == 2'd3);
      end
      c_DRAIN: begin
        if (m_ready && m_valid_q) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      default: begin
        enc_start_d = 2'b00;
        mem_sel_d   = 1'b1;
      end
    endcase
    if (wd_expire) begin
      enc_start_d = 2'b00;
      mem_sel_d   = 1'b1;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign enc_start = enc_start_q;
  assign mem_sel   = mem_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_encrypt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_encrypt_seq
// Purpose  : Self-checking bench for encrypt_seq: table blocks, reset aborts,
//            random blocks against a reference encrypt, optional watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encrypt_seq;

`ifdef ENCRYPT_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
  localparam int MAXRUN     = 3;
`else
  localparam int TB_TIMEOUT = 1023;
  localparam int MAXRUN     = 16;
`endif
  localparam logic [8:0] RD_BASE = 9'd256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic        mem_sel;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [1:0]  enc_start;
  logic [2:0]  enc_stop = 3'b000;
  logic        busy;
  logic        err;

  // Stand-in for the encrypt stage's side of the shared memory port.
  logic        enc_we = 1'b0;
  logic [8:0]  enc_addr = 9'd0;
  logic [31:0] enc_wdata = 32'd0;
  logic [31:0] mem [0:511];

  int n_checks = 0;
  int n_pass   = 0;

  encrypt_seq #(.TIMEOUT(TB_TIMEOUT), .RD_BASE(RD_BASE)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .enc_start(enc_start), .enc_stop(enc_stop),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_sel && mem_we)      mem[mem_addr] <= mem_wdata;
    else if (!mem_sel && enc_we) mem[enc_addr] <= enc_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct packed {
    logic [3:0][31:0] pt;
    logic [3:0][31:0] res;
    logic [3:0][3:0]  gap;
    logic [3:0][3:0]  stall;
    logic [3:0]       ack_dly;
    logic [4:0]       run_dly;
    logic             stale;
  } blk_t;

  blk_t tbl [3];

  function automatic logic [31:0] enc_ref(input logic [31:0] w, input int k);
    return {w[7:0], w[31:8]} ^ (32'h9E37_79B9 * (k + 1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_idle();
    chk("idle_s_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_mem_sel", mem_sel, 1);
    chk("idle_enc_start", enc_start, 0);
    chk("idle_m_valid", m_valid, 0);
    chk("idle_m_last", m_last, 0);
    chk("idle_m_data", m_data, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);
    chk("idle_err", err, 0);
  endtask

  // Called at a negedge; asserts reset between edges and checks it acts at once.
  task automatic do_reset();
    #2 reset = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0; enc_stop = 3'b000; enc_we = 1'b0;
    #1 chk_idle();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_spurious_m_valid", m_valid, 0);
    end
  endtask

  // abort: 0 = full block, 1 = reset in RUN, 2 = reset mid-DRAIN
  task automatic run_block(input blk_t b, input int abort);
    enc_stop = b.stale ? 3'b010 : 3'b000;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(b.gap[i]); g++) begin
        s_valid = 1'b0; s_data = $urandom;
        @(negedge clk);
        chk("idle_no_write", mem_we, 0);
      end
      chk("load_s_ready", s_ready, 1);
      s_valid = 1'b1; s_data = b.pt[i];
      @(negedge clk);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, i);
      chk("wr_data", mem_wdata, b.pt[i]);
      chk("wr_busy", busy, 1);
    end
    s_data = $urandom;
    chk("start1_s_ready", s_ready, 0);
    chk("start1_mem_sel", mem_sel, 1);
    chk("start1_enc_start", enc_start, 0);
    @(negedge clk);
    chk("start2_mem_sel", mem_sel, 0);
    chk("start2_enc_start", enc_start, 0);
    chk("start2_no_write", mem_we, 0);
    @(negedge clk);
    chk("start_go", enc_start, 2'b01);
    for (int k = 0; k < int'(b.ack_dly); k++) begin
      @(negedge clk);
      chk("start_hold", enc_start, 2'b01);
      chk("start_mem_sel", mem_sel, 0);
    end
    for (int i = 0; i < 4; i++) chk("pt_in_mem", mem[i], b.pt[i]);
    enc_stop = 3'b001;
    @(negedge clk);
    chk("start_drop", enc_start, 2'b00);
    enc_stop = 3'b000;
    if (abort == 1) begin
      do_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      enc_we = 1'b1; enc_addr = RD_BASE + 9'(k); enc_wdata = b.res[k];
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("run_mem_sel", mem_sel, 0);
      chk("run_s_ready", s_ready, 0);
    end
    enc_we = 1'b0;
    for (int k = 0; k < int'(b.run_dly); k++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("run_wait_mem_sel", mem_sel, 0);
      chk("run_wait_m_valid", m_valid, 0);
    end
    enc_stop = 3'b010; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("fetch_mem_sel", mem_sel, 1);
    enc_stop = 3'b000;
    for (int i = 0; i < 4; i++) begin
      chk("fetch_m_valid", m_valid, 0);
      @(negedge clk);
      chk("rd_addr", mem_addr, RD_BASE + 9'(i));
      chk("rd_we", mem_we, 0);
      @(negedge clk);
      chk("out_valid", m_valid, 1);
      chk("out_data", m_data, b.res[i]);
      chk("out_last", m_last, (i == 3));
      if (abort == 2 && i == 1) begin
        do_reset();
        return;
      end
      for (int s = 0; s < int'(b.stall[i]); s++) begin
        @(negedge clk);
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, b.res[i]);
        chk("stall_last", m_last, (i == 3));
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    chk("end_s_ready", s_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_m_valid", m_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    blk_t b;

    tbl[0].pt      = {32'h4, 32'h3, 32'h2, 32'h1};
    tbl[0].res     = {32'hD, 32'hC, 32'hB, 32'hA};
    tbl[0].gap     = {4'd0, 4'd0, 4'd0, 4'd0};
    tbl[0].stall   = {4'd0, 4'd1, 4'd2, 4'd0};
    tbl[0].ack_dly = 4'd3;
    tbl[0].run_dly = 5'(MAXRUN);
    tbl[0].stale   = 1'b1;

    tbl[1].pt      = {32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1234_5678, 32'h89AB_CDEF};
    tbl[1].res     = {32'h5555_AAAA, 32'hAAAA_5555, 32'h0F0F_F0F0, 32'hF0F0_0F0F};
    tbl[1].gap     = {4'd0, 4'd2, 4'd0, 4'd1};
    tbl[1].stall   = {4'd1, 4'd0, 4'd0, 4'd3};
    tbl[1].ack_dly = 4'd0;
    tbl[1].run_dly = 5'd0;
    tbl[1].stale   = 1'b0;

    tbl[2].pt      = {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[2].res     = {32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[2].gap     = {4'd1, 4'd1, 4'd1, 4'd1};
    tbl[2].stall   = {4'd2, 4'd2, 4'd2, 4'd2};
    tbl[2].ack_dly = 4'd1;
    tbl[2].run_dly = 5'd2;
    tbl[2].stale   = 1'b1;

    @(negedge clk);
    chk_idle();
    reset = 1'b1;
    @(negedge clk);
    chk_idle();

    for (int e = 0; e < 3; e++) run_block(tbl[e], 0);

    run_block(tbl[1], 1);
    run_block(tbl[2], 0);
    run_block(tbl[0], 2);
    run_block(tbl[1], 0);

    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) begin
        b.pt[k]    = $urandom;
        b.res[k]   = enc_ref(b.pt[k], k);
        b.gap[k]   = 4'($urandom_range(0, 2));
        b.stall[k] = 4'($urandom_range(0, 3));
      end
      b.ack_dly = 4'($urandom_range(0, 3));
      b.run_dly = 5'($urandom_range(0, MAXRUN));
      b.stale   = 1'($urandom_range(0, 1));
      run_block(b, 0);
    end

`ifdef ENCRYPT_SEQ_TIMEOUT_EN
    enc_stop = 3'b010;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int k = 0; k < TB_TIMEOUT - 1; k++) @(negedge clk);
    chk("wd_before_err", err, 0);
    chk("wd_before_s_ready", s_ready, 0);
    @(negedge clk);
    chk("wd_err", err, 1);
    chk("wd_s_ready", s_ready, 1);
    chk("wd_enc_start", enc_start, 0);
    chk("wd_mem_sel", mem_sel, 1);
    chk("wd_busy", busy, 0);
    s_valid = 1'b1; s_data = 32'h55;
    @(negedge clk);
    s_valid = 1'b0;
    chk("wd_err_clear", err, 0);
    chk("wd_restart_addr", mem_addr, 0);
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
